// File: rtl/regfile_mp_pkg.sv
// Shared sizing constants for the multi-port integer register file.
package regfile_mp_pkg;
    localparam int RegW   = 32;
    localparam int RegNum = 32;
    localparam int RegAW  = $clog2(RegNum);
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register select, x0 forced to zero, optional
// write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module rf_read_port
    import regfile_mp_pkg::*;
#(
    parameter int DW   = RegW,
    parameter int NREG = RegNum,
    parameter int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]              raddr,
    input  logic [NREG-1:0][DW-1:0]    regs,
    input  logic [NREG-1:0]            busy,
    input  logic                       we0,
    input  logic [AW-1:0]              waddr0,
    input  logic [DW-1:0]              wdata0,
    input  logic                       we1,
    input  logic [AW-1:0]              waddr1,
    input  logic [DW-1:0]              wdata1,
    input  logic                       issue,
    input  logic [AW-1:0]              issue_rd,
    output logic [DW-1:0]              rdata,
    output logic                       rbusy
);
    logic zero_addr;
    assign zero_addr = (raddr == '0);

`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1, issue_hit;
    assign hit0      = we0 && (waddr0 == raddr) && !zero_addr;
    assign hit1      = we1 && (waddr1 == raddr) && !zero_addr;
    assign issue_hit = issue && (issue_rd == raddr) && !zero_addr;

    // Port 1 data wins, matching the storage write priority.
    always_comb begin
        rdata = regs[raddr];
        if (zero_addr)
            rdata = '0;
        else if (hit1)
            rdata = wdata1;
        else if (hit0)
            rdata = wdata0;
    end

    assign rbusy = ((hit0 || hit1) && !issue_hit) ? 1'b0 : busy[raddr];
`else
    logic unused_bypass;
    assign unused_bypass = ^{we0, waddr0, wdata0, we1, waddr1, wdata1, issue, issue_rd};

    assign rdata = zero_addr ? '0 : regs[raddr];
    assign rbusy = busy[raddr];
`endif
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports and a per-register
// busy scoreboard. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW   = RegW,
    parameter int NREG = RegNum,
    parameter int AW   = $clog2(NREG),
    parameter int NR   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NR*AW-1:0]  raddr_i,
    output logic [NR*DW-1:0]  rdata_o,
    output logic [NR-1:0]     rbusy_o,
    input  logic              we0_i,
    input  logic [AW-1:0]     waddr0_i,
    input  logic [DW-1:0]     wdata0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     waddr1_i,
    input  logic [DW-1:0]     wdata1_i,
    input  logic              issue_i,
    input  logic [AW-1:0]     issue_rd_i,
    output logic [NREG-1:0]   busy_o
);
    logic [NREG-1:0][DW-1:0] regs;
    logic [NREG-1:0]         busy;

    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs <= '0;
        end else begin
            if (we0_i && waddr0_i != '0) regs[waddr0_i] <= wdata0_i;
            if (we1_i && waddr1_i != '0) regs[waddr1_i] <= wdata1_i;
        end
    end

    // A new producer issuing in the same cycle an older one retires keeps the bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (issue_i && issue_rd_i == AW'(r))
                    busy[r] <= 1'b1;
                else if ((we0_i && waddr0_i == AW'(r)) || (we1_i && waddr1_i == AW'(r)))
                    busy[r] <= 1'b0;
            end
        end
    end

    assign busy_o = busy;

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [DW-1:0] rdata;
        logic          rbusy;

        rf_read_port #(.DW(DW), .NREG(NREG), .AW(AW)) u_port (
            .raddr    (raddr_i[k*AW +: AW]),
            .regs     (regs),
            .busy     (busy),
            .we0      (we0_i),
            .waddr0   (waddr0_i),
            .wdata0   (wdata0_i),
            .we1      (we1_i),
            .waddr1   (waddr1_i),
            .wdata1   (wdata1_i),
            .issue    (issue_i),
            .issue_rd (issue_rd_i),
            .rdata    (rdata),
            .rbusy    (rbusy)
        );

        // Forwarded write data must not leak out while reset is held.
        assign rdata_o[k*DW +: DW] = rst_i ? '0 : rdata;
        assign rbusy_o[k]          = rst_i ? 1'b0 : rbusy;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (NR=4, 32 x 32-bit).
module tb_regfile_mp;
    localparam int DW = 32, NREG = 32, AW = 5, NR = 4;

    logic              clk, rst;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              we0, we1, issue;
    logic [AW-1:0]     waddr0, waddr1, issue_rd;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NREG-1:0]   busy;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp #(.DW(DW), .NREG(NREG), .AW(AW), .NR(NR)) dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .issue_i(issue), .issue_rd_i(issue_rd), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        we0 = 0; we1 = 0; issue = 0;
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rdata[k*DW +: DW];
    endfunction

    task automatic set_ra(input int k, input int a);
        raddr[k*AW +: AW] = AW'(a);
    endtask

    initial begin
        rst = 1; raddr = '0;
        we0 = 0; we1 = 0; issue = 0;
        waddr0 = '0; waddr1 = '0; issue_rd = '0; wdata0 = '0; wdata1 = '0;
        set_ra(0, 5);
        #12;
        chk("reset_rdata", 64'(rd(0)), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        rst = 0;
        tick();

        // Test 1: write x5 and mark busy, then async reset mid-cycle
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEAD_BEEF; issue = 1; issue_rd = 5;
        tick();
        chk("x5_written", 64'(rd(0)), 64'hDEAD_BEEF);
        chk("x5_busy", 64'(busy), 64'h20);
        #2 rst = 1;
        #1;
        chk("async_rst_rdata", 64'(rd(0)), 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        rst = 0;
        tick();

        // Test 2: x0 writes and issues are ignored
        we0 = 1; waddr0 = 0; wdata0 = 32'h1234; issue = 1; issue_rd = 0;
        set_ra(0, 0);
        tick();
        chk("x0_read", 64'(rd(0)), 64'h0);
        chk("x0_busy", 64'(busy), 64'h0);

        // Test 3: same-address collision, port 1 wins
        we0 = 1; waddr0 = 7; wdata0 = 32'h1111;
        we1 = 1; waddr1 = 7; wdata1 = 32'h2222;
        set_ra(1, 7);
        tick();
        chk("collision_x7", 64'(rd(1)), 64'h2222);

        // Test 4: scoreboard set / set-wins / clear
        issue = 1; issue_rd = 3; set_ra(2, 3);
        tick();
        chk("busy3_set", 64'(busy[3]), 64'h1);
        chk("rbusy3_set", 64'(rbusy[2]), 64'h1);
        we0 = 1; waddr0 = 3; wdata0 = 32'h33; issue = 1; issue_rd = 3;
        tick();
        chk("busy3_set_wins", 64'(busy[3]), 64'h1);
        chk("x3_data", 64'(rd(2)), 64'h33);
        we1 = 1; waddr1 = 3; wdata1 = 32'h44;
        tick();
        chk("busy3_clear", 64'(busy[3]), 64'h0);
        chk("x3_data2", 64'(rd(2)), 64'h44);
        we0 = 1; waddr0 = 3; wdata0 = 32'h55;
        tick();
        chk("nonbusy_write_busy", 64'(busy[3]), 64'h0);
        chk("nonbusy_write_data", 64'(rd(2)), 64'h55);

        // Test 5: same-cycle write to a read register
        we0 = 1; waddr0 = 9; wdata0 = 32'h1; issue = 1; issue_rd = 9;
        tick();
        set_ra(1, 9);
        we0 = 1; waddr0 = 9; wdata0 = 32'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", 64'(rd(1)), 64'hCAFE);
        chk("bypass_rbusy", 64'(rbusy[1]), 64'h0);
`else
        chk("nobypass_data", 64'(rd(1)), 64'h1);
        chk("nobypass_rbusy", 64'(rbusy[1]), 64'h1);
`endif
        tick();
        chk("x9_after", 64'(rd(1)), 64'hCAFE);
        chk("x9_busy_after", 64'(rbusy[1]), 64'h0);

        // Test 6: fill x1..x31, then sweep all four ports
        for (int i = 1; i < NREG; i += 2) begin
            we0 = 1; waddr0 = AW'(i); wdata0 = 32'h100 + 32'(i);
            if (i + 1 < NREG) begin
                we1 = 1; waddr1 = AW'(i + 1); wdata1 = 32'h100 + 32'(i + 1);
            end
            tick();
        end
        for (int b = 0; b < NREG; b += NR) begin
            for (int k = 0; k < NR; k++) set_ra(k, b + k);
            #1;
            for (int k = 0; k < NR; k++)
                chk($sformatf("sweep_x%0d_p%0d", b + k, k), 64'(rd(k)),
                    (b + k == 0) ? 64'h0 : 64'(32'h100 + 32'(b + k)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
